// File: rtl/prc_csr_pkg.sv
// Shared register map for the performance-counter CSR block: offsets, field positions,
// PERF stride and the address decoder used by both the read and the write paths.
package prc_csr_pkg;

  localparam logic [31:0] OFF_STATUS    = 32'h0000_0000;
  localparam logic [31:0] OFF_INT_RAW   = 32'h0000_0004;
  localparam logic [31:0] OFF_INT_EN    = 32'h0000_0008;
  localparam logic [31:0] OFF_INT_STAT  = 32'h0000_000C;
  localparam logic [31:0] OFF_CTRL      = 32'h0000_0010;
  localparam logic [31:0] OFF_PERF_BASE = 32'h0000_0020;
  localparam logic [31:0] PERF_STRIDE   = 32'h0000_0004;

  localparam int unsigned STATUS_DONE_BIT = 32'd0;
  localparam int unsigned INT_CFG_ERR_BIT = 32'd0;
  localparam int unsigned INT_OVF_BIT0    = 32'd1;
  localparam int unsigned CTRL_SNAP_BIT   = 32'd0;
  localparam int unsigned CTRL_CLR_BIT    = 32'd1;

  typedef enum logic [2:0] {
    REG_STATUS,
    REG_INT_RAW,
    REG_INT_EN,
    REG_INT_STAT,
    REG_CTRL,
    REG_PERF,
    REG_NONE
  } reg_sel_e;

  // Only exact, word-aligned hits are mapped; PERF is bounded by the channel count.
  function automatic reg_sel_e decode_reg(input logic [31:0] off, input logic [31:0] num_ch);
    reg_sel_e    sel;
    logic [31:0] perf_end;
    perf_end = OFF_PERF_BASE + (num_ch * PERF_STRIDE);
    case (off)
      OFF_STATUS:   sel = REG_STATUS;
      OFF_INT_RAW:  sel = REG_INT_RAW;
      OFF_INT_EN:   sel = REG_INT_EN;
      OFF_INT_STAT: sel = REG_INT_STAT;
      OFF_CTRL:     sel = REG_CTRL;
      default: begin
        if ((off >= OFF_PERF_BASE) && (off < perf_end) && (off[1:0] == 2'b00)) begin
          sel = REG_PERF;
        end else begin
          sel = REG_NONE;
        end
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/prc_csr_w1c.sv
// One sticky interrupt bit: hardware set has priority over a software write-1-to-clear.
module prc_csr_w1c (
  input  logic clk,
  input  logic resetn,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  // Sticky bit with set-over-clear priority
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_q;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/prc_csr.sv
// CSR window for the performance counters: status, sticky interrupts, control pulses, PERF reads.
// Define PRC_CSR_SNAPSHOT_EN to make PERF_n read an atomically captured copy instead of live counts.
module prc_csr
  import prc_csr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int          NUM_CH        = 3,
  parameter int          CYC_CNT_WIDTH = 28
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              wen,
  input  logic [31:0]                       waddr,
  input  logic [31:0]                       wdata,
  input  logic [7:0]                        wstrb,
  output logic                              wrdy,
  input  logic                              ren,
  input  logic [31:0]                       raddr,
  output logic [31:0]                       rdata,
  output logic                              rrdy,
  input  logic                              config_done,
  input  logic                              config_err,
  input  logic [NUM_CH*CYC_CNT_WIDTH-1:0]   cyc_cnt,
  input  logic [NUM_CH-1:0]                 cnt_ovf,
  output logic                              cnt_clr,
  output logic                              int_req
);

  localparam int RAW_W = NUM_CH + 1;

  logic [31:0]                      w_woff;
  logic [31:0]                      w_roff;
  logic [31:0]                      w_perf_idx;
  reg_sel_e                         w_wsel;
  reg_sel_e                         w_rsel;
  logic [RAW_W-1:0]                 w_lane_en;
  logic [RAW_W-1:0]                 w_raw_set;
  logic [RAW_W-1:0]                 w_raw_clr;
  logic [RAW_W-1:0]                 w_int_raw;
  logic                             w_ctrl_wr;
  logic [31:0]                      w_rd_val;
  logic [NUM_CH*CYC_CNT_WIDTH-1:0]  w_perf_src;
  logic                             w_unused;

  logic             r_cfg_err_d;
  logic [RAW_W-1:0] r_int_en;
  logic             r_cnt_clr;
  logic             r_int_req;
  logic             r_wrdy;
  logic             r_rrdy;
  logic [31:0]      r_rdata;

  assign w_woff     = waddr - BASE_ADDR;
  assign w_roff     = raddr - BASE_ADDR;
  assign w_wsel     = decode_reg(w_woff, 32'(NUM_CH));
  assign w_rsel     = decode_reg(w_roff, 32'(NUM_CH));
  assign w_perf_idx = (w_roff - OFF_PERF_BASE) / PERF_STRIDE;
  assign w_ctrl_wr  = wen && (w_wsel == REG_CTRL) && wstrb[0];
  // Strobes above byte 3 are outside the 32-bit data path and are dropped here.
  assign w_unused   = ^{wstrb, wdata};

  for (genvar g = 0; g < RAW_W; g++) begin : g_lane
    assign w_lane_en[g] = wstrb[g/8];
  end

  // Interrupt sources: rising edge of config_err, and each overflow pulse
  always_comb begin
    w_raw_set = {RAW_W{1'b0}};
    w_raw_set[INT_CFG_ERR_BIT] = config_err & ~r_cfg_err_d;
    w_raw_set[RAW_W-1:INT_OVF_BIT0] = cnt_ovf;
    if (wen && (w_wsel == REG_INT_RAW)) begin
      w_raw_clr = wdata[RAW_W-1:0] & w_lane_en;
    end else begin
      w_raw_clr = {RAW_W{1'b0}};
    end
  end

  for (genvar g = 0; g < RAW_W; g++) begin : g_raw
    prc_csr_w1c u_w1c (
      .clk    (clk),
      .resetn (resetn),
      .i_set  (w_raw_set[g]),
      .i_clr  (w_raw_clr[g]),
      .o_q    (w_int_raw[g])
    );
  end

`ifdef PRC_CSR_SNAPSHOT_EN
  logic [NUM_CH*CYC_CNT_WIDTH-1:0] r_snap;

  // Capture every channel on the same edge so PERF reads form a coherent set
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_snap <= {(NUM_CH*CYC_CNT_WIDTH){1'b0}};
    end else if (w_ctrl_wr && wdata[CTRL_SNAP_BIT]) begin
      r_snap <= cyc_cnt;
    end else begin
      r_snap <= r_snap;
    end
  end

  assign w_perf_src = r_snap;
`else
  assign w_perf_src = cyc_cnt;
`endif

  // Read mux; all fields zero-extended, unmapped offsets and CTRL read as zero
  always_comb begin
    w_rd_val = 32'h0000_0000;
    case (w_rsel)
      REG_STATUS:   w_rd_val[STATUS_DONE_BIT] = config_done;
      REG_INT_RAW:  w_rd_val[RAW_W-1:0] = w_int_raw;
      REG_INT_EN:   w_rd_val[RAW_W-1:0] = r_int_en;
      REG_INT_STAT: w_rd_val[RAW_W-1:0] = w_int_raw & r_int_en;
      REG_CTRL:     w_rd_val = 32'h0000_0000;
      REG_PERF: begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (w_perf_idx == 32'(ch)) begin
            w_rd_val[CYC_CNT_WIDTH-1:0] = w_perf_src[ch*CYC_CNT_WIDTH +: CYC_CNT_WIDTH];
          end else begin
            w_rd_val = w_rd_val;
          end
        end
      end
      default:      w_rd_val = 32'h0000_0000;
    endcase
  end

  // Bus handshake, interrupt enable, control pulse and interrupt output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cfg_err_d <= 1'b0;
      r_int_en    <= {RAW_W{1'b0}};
      r_cnt_clr   <= 1'b0;
      r_int_req   <= 1'b0;
      r_wrdy      <= 1'b0;
      r_rrdy      <= 1'b0;
      r_rdata     <= 32'h0000_0000;
    end else begin
      r_cfg_err_d <= config_err;
      r_wrdy      <= wen;
      r_rrdy      <= ren;
      r_cnt_clr   <= w_ctrl_wr & wdata[CTRL_CLR_BIT];
      r_int_req   <= |(w_int_raw & r_int_en);
      if (wen && (w_wsel == REG_INT_EN)) begin
        r_int_en <= (r_int_en & ~w_lane_en) | (wdata[RAW_W-1:0] & w_lane_en);
      end else begin
        r_int_en <= r_int_en;
      end
      if (ren) begin
        r_rdata <= w_rd_val;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  assign wrdy    = r_wrdy;
  assign rrdy    = r_rrdy;
  assign rdata   = r_rdata;
  assign cnt_clr = r_cnt_clr;
  assign int_req = r_int_req;

endmodule

// File: tb/tb_prc_csr.sv
// Self-checking bench for prc_csr: directed vector table, random traffic against a
// behavioural register model, and reset corner cases.
module tb_prc_csr;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NCH   = 3;
  localparam int          W     = 28;
  localparam int          RAW_W = NCH + 1;
`ifdef PRC_CSR_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic              clk;
  logic              resetn;
  logic              wen;
  logic [31:0]       waddr;
  logic [31:0]       wdata;
  logic [7:0]        wstrb;
  logic              wrdy;
  logic              ren;
  logic [31:0]       raddr;
  logic [31:0]       rdata;
  logic              rrdy;
  logic              config_done;
  logic              config_err;
  logic [NCH*W-1:0]  cyc_cnt;
  logic [NCH-1:0]    cnt_ovf;
  logic              cnt_clr;
  logic              int_req;

  prc_csr #(.BASE_ADDR(BASE), .NUM_CH(NCH), .CYC_CNT_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wrdy(wrdy),
    .ren(ren), .raddr(raddr), .rdata(rdata), .rrdy(rrdy),
    .config_done(config_done), .config_err(config_err),
    .cyc_cnt(cyc_cnt), .cnt_ovf(cnt_ovf), .cnt_clr(cnt_clr), .int_req(int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [7:0]  ws;
    bit          re;
    logic [31:0] ra;
    bit          dn;
    bit          er;
    logic [2:0]  ov;
    logic [27:0] c1;
    logic [31:0] e_rdata;
    bit          e_clr;
    bit          e_irq;
  } vec_t;

  vec_t tab[31];

  // Behavioural model state: register contents as plain integers
  int unsigned m_raw, m_en;
  bit          m_prev_err;
  logic [W-1:0] m_snap[NCH];
  logic [31:0] m_rdata;
  bit          m_rrdy, m_wrdy, m_clr, m_irq;

  function automatic vec_t v(bit we, logic [31:0] wa, logic [31:0] wd, logic [7:0] ws,
                             bit re, logic [31:0] ra, bit dn, bit er, logic [2:0] ov,
                             logic [27:0] c1, logic [31:0] erd, bit ec, bit ei);
    vec_t r;
    r.we = we; r.wa = wa; r.wd = wd; r.ws = ws; r.re = re; r.ra = ra;
    r.dn = dn; r.er = er; r.ov = ov; r.c1 = c1;
    r.e_rdata = erd; r.e_clr = ec; r.e_irq = ei;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_raw = 0; m_en = 0; m_prev_err = 1'b0;
    for (int i = 0; i < NCH; i++) m_snap[i] = '0;
    m_rdata = 32'h0; m_rrdy = 1'b0; m_wrdy = 1'b0; m_clr = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] addr);
    logic [31:0] off;
    int unsigned idx;
    off = addr - BASE;
    if (off == 32'h00) return {31'h0, config_done};
    if (off == 32'h04) return m_raw;
    if (off == 32'h08) return m_en;
    if (off == 32'h0C) return m_raw & m_en;
    if (off >= 32'h20 && off < 32'h20 + 4 * NCH && (off % 4) == 0) begin
      idx = (off - 32'h20) / 4;
      if (SNAP) return 32'(m_snap[idx]);
      return 32'(cyc_cnt[idx*W +: W]);
    end
    return 32'h0;
  endfunction

  // One clock: predict from current inputs, advance, then compare on the falling edge
  task automatic tick(input bit use_tab, input vec_t e);
    logic [31:0] mask, woff, n_rdata;
    int unsigned set, clr, n_raw, n_en, rawmask;
    bit n_clr, n_irq;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (wstrb[b]) mask |= 32'hFF << (8 * b);
    rawmask = (1 << RAW_W) - 1;
    woff = waddr - BASE;
    set = ((config_err && !m_prev_err) ? 1 : 0) | (32'(cnt_ovf) << 1);
    clr = (wen && woff == 32'h04) ? (wdata & mask) : 0;
    n_raw = ((m_raw & ~clr) | set) & rawmask;
    n_en = (wen && woff == 32'h08) ? (((m_en & ~mask) | (wdata & mask)) & rawmask) : m_en;
    n_clr = wen && woff == 32'h10 && wstrb[0] && wdata[1];
    n_irq = (m_raw & m_en) != 0;
    n_rdata = ren ? m_read(raddr) : m_rdata;
    @(posedge clk);
    if (wen && woff == 32'h10 && wstrb[0] && wdata[0])
      for (int i = 0; i < NCH; i++) m_snap[i] = cyc_cnt[i*W +: W];
    m_raw = n_raw; m_en = n_en; m_clr = n_clr; m_irq = n_irq; m_rdata = n_rdata;
    m_rrdy = ren; m_wrdy = wen; m_prev_err = config_err;
    @(negedge clk);
    if (use_tab) begin
      chk("tab_rrdy", 32'(rrdy), 32'(e.re));
      chk("tab_wrdy", 32'(wrdy), 32'(e.we));
      chk("tab_cnt_clr", 32'(cnt_clr), 32'(e.e_clr));
      chk("tab_int_req", 32'(int_req), 32'(e.e_irq));
      chk("tab_rdata", rdata, e.e_rdata);
    end else begin
      chk("rnd_rrdy", 32'(rrdy), 32'(m_rrdy));
      chk("rnd_wrdy", 32'(wrdy), 32'(m_wrdy));
      chk("rnd_cnt_clr", 32'(cnt_clr), 32'(m_clr));
      chk("rnd_int_req", 32'(int_req), 32'(m_irq));
      chk("rnd_rdata", rdata, m_rdata);
    end
  endtask

  task automatic idle_inputs();
    wen = 1'b0; waddr = 32'h0; wdata = 32'h0; wstrb = 8'h0;
    ren = 1'b0; raddr = 32'h0; config_err = 1'b0; cnt_ovf = '0; cyc_cnt = '0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_rrdy"}, 32'(rrdy), 32'h0);
    chk({tag, "_wrdy"}, 32'(wrdy), 32'h0);
    chk({tag, "_cnt_clr"}, 32'(cnt_clr), 32'h0);
    chk({tag, "_int_req"}, 32'(int_req), 32'h0);
  endtask

  logic [31:0] offs[12];
  vec_t dummy;

  initial begin
    offs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14,
             32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    //          we  waddr  wdata         ws     re  raddr dn er ov    ch1      rdata                 clr irq
    tab[0]  = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[1]  = v(0, 32'h00, 32'h0,        8'h00, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[2]  = v(1, 32'h08, 32'h1,        8'h0F, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[3]  = v(0, 32'h00, 32'h0,        8'h00, 0, 32'h00, 1, 1, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[4]  = v(0, 32'h00, 32'h0,        8'h00, 0, 32'h00, 1, 1, 3'b000, 28'h0,   32'h1,                0, 1);
    tab[5]  = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h04, 1, 1, 3'b000, 28'h0,   32'h1,                0, 1);
    tab[6]  = v(1, 32'h04, 32'h1,        8'h0F, 0, 32'h00, 1, 1, 3'b000, 28'h0,   32'h1,                0, 1);
    tab[7]  = v(0, 32'h00, 32'h0,        8'h00, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[8]  = v(1, 32'h04, 32'h2,        8'h0F, 0, 32'h00, 1, 0, 3'b001, 28'h0,   32'h1,                0, 0);
    tab[9]  = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h04, 1, 0, 3'b000, 28'h0,   32'h2,                0, 0);
    tab[10] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h0C, 1, 0, 3'b000, 28'h0,   32'h0,                0, 0);
    tab[11] = v(1, 32'h08, 32'hF,        8'h00, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h0,                0, 0);
    tab[12] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h08, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[13] = v(1, 32'h08, 32'hF,        8'hF0, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[14] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h08, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[15] = v(1, 32'h08, 32'hFFFFFFFF, 8'h01, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[16] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h0C, 1, 0, 3'b000, 28'h0,   32'h2,                0, 1);
    tab[17] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h2C, 1, 0, 3'b000, 28'h0,   32'h0,                0, 1);
    tab[18] = v(1, 32'h10, 32'h2,        8'h01, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h0,                1, 1);
    tab[19] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h10, 1, 0, 3'b000, 28'h0,   32'h0,                0, 1);
    tab[20] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h24, 1, 0, 3'b000, 28'h123, SNAP ? 32'h0 : 32'h123, 0, 1);
    tab[21] = v(1, 32'h10, 32'h1,        8'h01, 0, 32'h00, 1, 0, 3'b000, 28'h123, SNAP ? 32'h0 : 32'h123, 0, 1);
    tab[22] = v(0, 32'h00, 32'h0,        8'h00, 0, 32'h00, 1, 0, 3'b000, 28'h456, SNAP ? 32'h0 : 32'h123, 0, 1);
    tab[23] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h24, 1, 0, 3'b000, 28'h456, SNAP ? 32'h123 : 32'h456, 0, 1);
    tab[24] = v(1, 32'h08, 32'h0,        8'h0F, 1, 32'h08, 1, 0, 3'b000, 28'h0,   32'hF,                0, 1);
    tab[25] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h08, 1, 0, 3'b000, 28'h0,   32'h0,                0, 0);
    tab[26] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h00, 1, 0, 3'b000, 28'h0,   32'h1,                0, 0);
    tab[27] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h14, 1, 0, 3'b000, 28'h0,   32'h0,                0, 0);
    tab[28] = v(1, 32'h00, 32'h0,        8'h0F, 0, 32'h00, 1, 0, 3'b000, 28'h0,   32'h0,                0, 0);
    tab[29] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h04, 1, 0, 3'b000, 28'h0,   32'h2,                0, 0);
    tab[30] = v(0, 32'h00, 32'h0,        8'h00, 1, 32'h00, 0, 0, 3'b000, 28'h0,   32'h0,                0, 0);
    dummy = tab[0];

    // Reset with a read request pending: nothing may be acknowledged
    resetn = 1'b0; config_done = 1'b1;
    idle_inputs();
    ren = 1'b1; raddr = 32'h0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    ren = 1'b0;
    resetn = 1'b1;

    // Directed vectors
    for (int i = 0; i < 31; i++) begin
      wen = tab[i].we; waddr = BASE + tab[i].wa; wdata = tab[i].wd; wstrb = tab[i].ws;
      ren = tab[i].re; raddr = BASE + tab[i].ra;
      config_done = tab[i].dn; config_err = tab[i].er; cnt_ovf = tab[i].ov;
      cyc_cnt = '0; cyc_cnt[W +: W] = tab[i].c1;
      tick(1'b1, tab[i]);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      wen = 1'($urandom_range(0, 1));
      ren = 1'($urandom_range(0, 1));
      waddr = BASE + (($urandom_range(0, 12) == 12) ? ($urandom & 32'hFC) : offs[$urandom_range(0, 11)]);
      raddr = BASE + (($urandom_range(0, 12) == 12) ? ($urandom & 32'hFC) : offs[$urandom_range(0, 11)]);
      wdata = $urandom;
      wstrb = 8'($urandom);
      config_done = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) config_err = ~config_err;
      for (int c = 0; c < NCH; c++) begin
        cnt_ovf[c] = ($urandom_range(0, 7) == 0);
        cyc_cnt[c*W +: W] = W'($urandom);
      end
      tick(1'b0, dummy);
    end

    // Reset asserted while a write and a read are in flight
    idle_inputs();
    wen = 1'b1; waddr = BASE + 32'h08; wdata = 32'hF; wstrb = 8'h0F;
    ren = 1'b1; raddr = BASE + 32'h04;
    #2 resetn = 1'b0;
    @(posedge clk); #1;
    reset_checks("inflight_reset");
    @(negedge clk);
    idle_inputs();
    model_reset();
    resetn = 1'b1;
    ren = 1'b1; raddr = BASE + 32'h08;
    tick(1'b0, dummy);
    chk("post_reset_int_en", rdata, 32'h0);
    raddr = BASE + 32'h04;
    tick(1'b0, dummy);
    chk("post_reset_int_raw", rdata, 32'h0);
    ren = 1'b0;
    tick(1'b0, dummy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
